// File: rtl/vga_pkg.sv
// Shared geometry, colour width and fill-engine state encoding for the VGA renderer.
package vga_pkg;

    localparam int FB_W        = 80;
    localparam int FB_H        = 60;
    localparam int SCALE_SHIFT = 3;
    localparam int COLOR_W     = 12;

    typedef logic [COLOR_W-1:0] color_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } fill_state_t;

endpackage

// File: rtl/fb_dpram.sv
// Double framebuffer storage: synchronous write, asynchronous read, buffer select in address MSB.
// No reset on contents; read data follows raddr in the same cycle.
module fb_dpram
    import vga_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  color_t            wdata,
    input  logic [ADDR_W-1:0] raddr,
    output color_t            rdata
);

    color_t mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/vga_frame_renderer.sv
// Double-buffered framebuffer with rectangle fill engine; pixel read is combinational,
// one back-buffer pixel written per cycle, commands held off while busy or a swap is pending.
module vga_frame_renderer #(
    parameter int FB_W        = vga_pkg::FB_W,
    parameter int FB_H        = vga_pkg::FB_H,
    parameter int SCALE_SHIFT = vga_pkg::SCALE_SHIFT
) (
    input  logic        vga_clk,
    input  logic        rst,
    input  logic [8:0]  row_addr,
    input  logic [9:0]  col_addr,
    input  logic        rdn,
    input  logic        vs,
    output logic [11:0] d_in,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [6:0]  cmd_x,
    input  logic [5:0]  cmd_y,
    input  logic [6:0]  cmd_w,
    input  logic [5:0]  cmd_h,
    input  logic [11:0] cmd_color,
    output logic        cmd_done,
    input  logic        swap_req,
    output logic        swap_pending,
    output logic        front_sel
);
    import vga_pkg::*;

    localparam int OFS_W  = $clog2(FB_W * FB_H);
    localparam int ADDR_W = OFS_W + 1;

    localparam logic [9:0] SCR_W_L = 10'(FB_W << SCALE_SHIFT);
    localparam logic [8:0] SCR_H_L = 9'(FB_H << SCALE_SHIFT);
    localparam logic [7:0] FB_W_L  = 8'(FB_W);
    localparam logic [7:0] FB_H_L  = 8'(FB_H);

    fill_state_t state, state_nxt;
    logic        done_nxt;
    logic        fill_we;

    logic [7:0]  cur_x, cur_y, x_start, x_end, y_end;
    color_t      fill_color;
    logic        vs_q;

    // Read path: scale screen coordinates down to framebuffer cells in the front buffer.
    logic [8:0]       fy;
    logic [9:0]       fx;
    logic [OFS_W-1:0] rd_ofs, wr_ofs;
    color_t           rd_data;
    logic             rd_hit;

    assign fy     = row_addr >> SCALE_SHIFT;
    assign fx     = col_addr >> SCALE_SHIFT;
    assign rd_ofs = OFS_W'(fy) * OFS_W'(FB_W) + OFS_W'(fx);
    assign rd_hit = !rdn && (row_addr < SCR_H_L) && (col_addr < SCR_W_L);
    assign d_in   = rd_hit ? rd_data : 12'h000;

    // Command acceptance and clipping, all at 8 bits so x+w and y+h cannot overflow.
    logic       accept, cmd_empty, x_last, y_last;
    logic [7:0] x_sum, y_sum, x_clip, y_clip;

    assign cmd_ready = (state == ST_IDLE) && !swap_pending;
    assign accept    = cmd_valid && cmd_ready;
    assign x_sum     = {1'b0, cmd_x} + {1'b0, cmd_w};
    assign y_sum     = {2'b0, cmd_y} + {2'b0, cmd_h};
    assign x_clip    = (x_sum > FB_W_L) ? FB_W_L : x_sum;
    assign y_clip    = (y_sum > FB_H_L) ? FB_H_L : y_sum;
    assign cmd_empty = (cmd_w == 7'd0) || (cmd_h == 6'd0) ||
                       ({1'b0, cmd_x} >= FB_W_L) || ({2'b0, cmd_y} >= FB_H_L);
    assign x_last    = (cur_x == x_end - 8'd1);
    assign y_last    = (cur_y == y_end - 8'd1);

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        fill_we   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (cmd_empty) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                fill_we = 1'b1;
                if (x_last && y_last) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cmd_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            cmd_done <= done_nxt;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (accept) begin
            cur_x      <= {1'b0, cmd_x};
            cur_y      <= {2'b0, cmd_y};
            x_start    <= {1'b0, cmd_x};
            x_end      <= x_clip;
            y_end      <= y_clip;
            fill_color <= cmd_color;
        end else if (state == ST_FILL) begin
            if (x_last) begin
                cur_x <= x_start;
                cur_y <= cur_y + 8'd1;
            end else begin
                cur_x <= cur_x + 8'd1;
            end
        end
    end

    // Swap only lands while idle, so a fill never straddles a front/back change.
    logic do_swap;
    assign do_swap = vs_q && !vs && swap_pending && (state == ST_IDLE);

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            front_sel    <= 1'b0;
            swap_pending <= 1'b0;
            vs_q         <= 1'b1;
        end else begin
            vs_q <= vs;
            if (do_swap) begin
                front_sel    <= ~front_sel;
                swap_pending <= 1'b0;
            end else if (swap_req) begin
                swap_pending <= 1'b1;
            end
        end
    end

    assign wr_ofs = OFS_W'(cur_y) * OFS_W'(FB_W) + OFS_W'(cur_x);

    fb_dpram #(
        .ADDR_W(ADDR_W)
    ) u_fb (
        .clk  (vga_clk),
        .we   (fill_we && !rst),
        .waddr({~front_sel, wr_ofs}),
        .wdata(fill_color),
        .raddr({front_sel, rd_ofs}),
        .rdata(rd_data)
    );

endmodule

// File: doc/vga_frame_renderer.md
VGA_FRAME_RENDERER -- requirements
Module: vga_frame_renderer

Interface
REQ-001 SHALL have parameter FB_W, default 80: framebuffer width in pixels.
REQ-002 SHALL have parameter FB_H, default 60: framebuffer height in pixels.
REQ-003 SHALL have parameter SCALE_SHIFT, default 3: each framebuffer pixel covers 8x8 screen pixels.
REQ-004 Ports:
- vga_clk  in  1  single clock, 25 MHz, same clock as the VGA timing controller.
- rst  in  1  synchronous, active-high reset.
- row_addr  in  9  screen row from the timing controller.
- col_addr  in  10  screen column from the timing controller.
- rdn  in  1  pixel read strobe, active low.
- vs  in  1  vertical sync from the timing controller.
- d_in  out  12  pixel to the timing controller, bbbb_gggg_rrrr.
- cmd_valid  in  1  fill command offered.
- cmd_ready  out  1  fill engine accepts a command.
- cmd_x  in  7  rectangle left edge.
- cmd_y  in  6  rectangle top edge.
- cmd_w  in  7  rectangle width.
- cmd_h  in  6  rectangle height.
- cmd_color  in  12  fill colour, bbbb_gggg_rrrr.
- cmd_done  out  1  one-cycle pulse when a fill completes.
- swap_req  in  1  request a front/back buffer swap.
- swap_pending  out  1  swap requested, not yet performed.
- front_sel  out  1  index of the buffer being displayed.

Function
REQ-005 SHALL hold two framebuffers, each FB_W x FB_H x 12 bit; front = front_sel, back = ~front_sel.
REQ-006 SHALL drive d_in combinationally with zero-cycle latency: d_in = front[row_addr>>SCALE_SHIFT][col_addr>>SCALE_SHIFT].
REQ-007 SHALL drive d_in = 12'h000 when rdn=1, row_addr>=FB_H<<SCALE_SHIFT, or col_addr>=FB_W<<SCALE_SHIFT.
REQ-008 Fill FSM SHALL have exactly two states: IDLE and FILL.
REQ-009 cmd_ready SHALL be 1 only when state=IDLE and swap_pending=0.
REQ-010 A command SHALL be accepted on a cycle where cmd_valid=1 and cmd_ready=1.
REQ-011 On acceptance, the engine SHALL capture all cmd_* fields and clip the rectangle: x_end = min(cmd_x+cmd_w, FB_W) and y_end = min(cmd_y+cmd_h, FB_H), computed at 8-bit width with no overflow.
REQ-012 If cmd_w=0, cmd_h=0, cmd_x>=FB_W or cmd_y>=FB_H, the engine SHALL stay in IDLE, write nothing, and pulse cmd_done on the next cycle.
REQ-013 In FILL, the engine SHALL write one back-buffer pixel per cycle in raster order (x inner, y outer), starting the first write in the cycle after acceptance.
REQ-014 After writing (x_end-1, y_end-1), the engine SHALL return to IDLE and pulse cmd_done for exactly one cycle.
REQ-015 Latency from acceptance to cmd_done SHALL be (clipped width x clipped height) + 1 cycles.
REQ-016 The engine SHALL never write the front buffer.
REQ-017 A swap_req=1 in any cycle SHALL set swap_pending on the next edge.
REQ-018 A swap_req while swap_pending=1 SHALL have no additional effect.
REQ-019 The swap SHALL occur on the cycle after a registered 1->0 transition of vs with state=IDLE: front_sel toggles and swap_pending clears.
REQ-020 If state=FILL at the vs falling edge, the swap SHALL be deferred to the next vs falling edge.
REQ-021 swap_req coincident with a command acceptance: the command SHALL be accepted and swap_pending set; the swap follows per REQ-019/020.

Reset
REQ-022 While rst=1, the block SHALL set state=IDLE, front_sel=0, swap_pending=0, cmd_done=0 and the vs history register=1.
REQ-023 Reset asserted mid-FILL SHALL abort the fill without a cmd_done pulse; pixels already written remain.
REQ-024 Framebuffer contents SHALL NOT be cleared by reset.

Structure
REQ-025 FB_W, FB_H, SCALE_SHIFT, the 12-bit colour width and the FSM state encoding SHALL live in a shared package, vga_pkg.
REQ-026 Storage SHALL be one sub-module, fb_dpram: one synchronous write port, one asynchronous read port, buffer-select bit as the MSB of the address. The renderer instantiates it once.

Verification
REQ-027 Scenario: after reset, fill (0,0,80,60,12'hF00) -> cmd_done exactly 4801 cycles after acceptance; front still reads old data; swap_req then vs fall -> front_sel=1 and d_in=12'hF00 at row 0, col 0 with rdn=0.
REQ-028 Scenario: fill (75,58,10,10,12'h0F0) -> exactly 10 writes (5x2), cmd_done 11 cycles after acceptance, no write wraps to x<75.
REQ-029 Scenario: command with cmd_w=0 -> cmd_done one cycle after acceptance, back buffer unchanged.
REQ-030 Scenario: swap_req during a 100-pixel fill, vs falling edge at fill cycle 50 -> no swap at that edge; swap at the next vs fall; cmd_ready=0 throughout the pending period.
REQ-031 Scenario: rdn=1, or col_addr=700, or row_addr=500 -> d_in=12'h000 regardless of buffer contents.
REQ-032 Scenario: rst asserted at fill cycle 20 -> state IDLE, no cmd_done, front_sel=0, first 20 pixels retain the fill colour.
